kernel_cc_fifo_srl_param: RTL and testbench

Parametrised shift-register FIFO, successor to the fixed-size HLS stream FIFOs in kernel_cc. Depth and width are generic. Adds an occupancy count, registered almost-full/almost-empty flags, a synchronous flush and sticky overflow/underflow error flags. Sits between dataflow processes on hls::stream channels, and is drop-in compatible with the existing if_* handshake.

---
 rtl/kernel_cc_pkg.sv | 16 +
 rtl/kernel_cc_fifo_srl_param_shiftReg.sv | 28 ++
 rtl/kernel_cc_fifo_srl_param.sv | 101 ++++++++++
 tb/tb_kernel_cc_fifo_srl_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/kernel_cc_pkg.sv
// Shared constants and helpers for the kernel_cc stream FIFOs.
package kernel_cc_pkg;

  localparam string MEM_STYLE = "shiftreg";

  // Bits needed to address 'value' distinct items (value >= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/kernel_cc_fifo_srl_param_shiftReg.sv
// Reset-less addressable shift register; maps onto SRL primitives.
module kernel_cc_fifo_srl_param_shiftReg #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] sr_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      sr_reg[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        sr_reg[i] <= sr_reg[i-1];
      end
    end
  end

  // Non-power-of-two depths leave unused address codes; return zero there.
  assign q = (int'(a) < DEPTH) ? sr_reg[a] : '0;

endmodule

// File: rtl/kernel_cc_fifo_srl_param.sv
// Parametrised first-word-fall-through SRL FIFO with occupancy, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
module kernel_cc_fifo_srl_param
  import kernel_cc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int ADDR_WIDTH = clog2(DEPTH),
  localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  input  logic                  if_flush,
  output logic [CNT_WIDTH-1:0]  if_count,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_ovf,
  output logic                  if_udf
);

  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic                  full_n_reg, empty_n_reg;
  logic                  af_reg, ae_reg, ovf_reg, udf_reg;
  logic                  wr, rd, shift_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr       = if_write & if_write_ce & full_n_reg;
  assign rd       = if_read & if_read_ce & empty_n_reg;
  assign shift_en = wr & ~if_flush;
  // Oldest entry sits at count-1; a write+read shifts it forward in place.
  assign rd_addr  = (count_reg != '0) ? ADDR_WIDTH'(count_reg - 1'b1) : '0;

  always_comb begin
    count_next = count_reg;
    if (if_flush) begin
      count_next = '0;
    end else if (wr && !rd) begin
      count_next = count_reg + 1'b1;
    end else if (rd && !wr) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg   <= '0;
      empty_n_reg <= 1'b0;
      full_n_reg  <= 1'b1;
      af_reg      <= 1'b0;
      ae_reg      <= 1'b1;
      ovf_reg     <= 1'b0;
      udf_reg     <= 1'b0;
    end else begin
      count_reg   <= count_next;
      empty_n_reg <= (count_next != '0);
      full_n_reg  <= (count_next != CNT_WIDTH'(DEPTH));
      af_reg      <= (int'(count_next) >= AF_THRESH);
      ae_reg      <= (int'(count_next) <= AE_THRESH);
      ovf_reg     <= !if_flush && (ovf_reg || (if_write && if_write_ce && !full_n_reg));
      udf_reg     <= !if_flush && (udf_reg || (if_read && if_read_ce && !empty_n_reg));
    end
  end

  kernel_cc_fifo_srl_param_shiftReg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_shift_reg (
    .clk (clk),
    .data(if_din),
    .ce  (shift_en),
    .a   (rd_addr),
    .q   (if_dout)
  );

  assign if_count        = count_reg;
  assign if_full_n       = full_n_reg;
  assign if_empty_n      = empty_n_reg;
  assign if_almost_full  = af_reg;
  assign if_almost_empty = ae_reg;
  assign if_ovf          = ovf_reg;
  assign if_udf          = udf_reg;

  count_le_depth_a: assert property (@(posedge clk) disable iff (!reset_n)
    int'(count_reg) <= DEPTH);
  no_pop_when_empty_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(rd && !wr && !if_flush && count_reg == '0));
  no_push_when_full_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(wr && !rd && !if_flush && int'(count_reg) == DEPTH));

endmodule

// File: tb/tb_kernel_cc_fifo_srl_param.sv
// Self-checking bench: directed vector table, async-reset sequence and random traffic vs a queue model.
module tb_kernel_cc_fifo_srl_param;

  localparam int W  = 64;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  if_din;
  logic          if_write, if_write_ce, if_read, if_read_ce, if_flush;
  logic          if_full_n, if_empty_n, if_almost_full, if_almost_empty, if_ovf, if_udf;
  logic [W-1:0]  if_dout;
  logic [CW-1:0] if_count;

  always #5 clk = ~clk;

  kernel_cc_fifo_srl_param #(
    .DATA_WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_din(if_din), .if_write(if_write), .if_write_ce(if_write_ce), .if_full_n(if_full_n),
    .if_dout(if_dout), .if_read(if_read), .if_read_ce(if_read_ce), .if_empty_n(if_empty_n),
    .if_flush(if_flush), .if_count(if_count),
    .if_almost_full(if_almost_full), .if_almost_empty(if_almost_empty),
    .if_ovf(if_ovf), .if_udf(if_udf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 ns after the capturing edge.
  task automatic drive(input bit w, input bit wce, input bit r, input bit rce,
                       input bit fl, input logic [63:0] din);
    if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce;
    if_flush = fl; if_din = din;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit w, wce, r, rce, fl;
    logic [63:0] din;
    int cnt;
    logic [63:0] dout;
    bit ovf, udf, af, ae;
  } vec_t;

  function automatic vec_t mk(bit w, bit r, bit fl, logic [63:0] din, int cnt,
                              logic [63:0] dout, bit ovf, bit udf, bit af, bit ae);
    vec_t v;
    v.w = w; v.wce = 1'b1; v.r = r; v.rce = 1'b1; v.fl = fl; v.din = din;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf; v.af = af; v.ae = ae;
    return v;
  endfunction

  // Reference model: a plain queue with the handshake acceptance rules.
  logic [63:0] mq[$];
  bit m_ovf, m_udf;

  task automatic model_apply(input bit w, input bit wce, input bit r, input bit rce,
                             input bit fl, input logic [63:0] din);
    bit full, empty;
    full  = (mq.size() == D);
    empty = (mq.size() == 0);
    if (fl) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (w && wce && full)  m_ovf = 1;
      if (r && rce && empty) m_udf = 1;
      if (r && rce && !empty) void'(mq.pop_front());
      if (w && wce && !full)  mq.push_back(din);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},   64'(if_count), 64'(n));
    chk({tag, ".empty_n"}, 64'(if_empty_n), 64'(n > 0));
    chk({tag, ".full_n"},  64'(if_full_n), 64'(n < D));
    chk({tag, ".af"},      64'(if_almost_full), 64'(n >= AF));
    chk({tag, ".ae"},      64'(if_almost_empty), 64'(n <= AE));
    chk({tag, ".ovf"},     64'(if_ovf), 64'(m_ovf));
    chk({tag, ".udf"},     64'(if_udf), 64'(m_udf));
    if (n > 0) chk({tag, ".dout"}, if_dout, mq[0]);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".count"},   64'(if_count), 64'd0);
    chk({tag, ".empty_n"}, 64'(if_empty_n), 64'd0);
    chk({tag, ".full_n"},  64'(if_full_n), 64'd1);
    chk({tag, ".af"},      64'(if_almost_full), 64'd0);
    chk({tag, ".ae"},      64'(if_almost_empty), 64'd1);
    chk({tag, ".ovf"},     64'(if_ovf), 64'd0);
    chk({tag, ".udf"},     64'(if_udf), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[26];
    string tag;

    tbl[0]  = mk(1, 0, 0, 64'h11, 1, 64'h11, 0, 0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 64'h22, 2, 64'h11, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 64'h33, 3, 64'h11, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 64'h44, 4, 64'h11, 0, 0, 1, 0);
    tbl[4]  = mk(1, 0, 0, 64'h55, 5, 64'h11, 0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0, 64'h66, 5, 64'h11, 1, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 64'h0,  4, 64'h22, 1, 0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 64'h0,  3, 64'h33, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 64'h0,  2, 64'h44, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 64'h0,  1, 64'h55, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 64'h0,  0, 64'h0,  0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 64'h0,  0, 64'h0,  0, 0, 0, 1);
    tbl[12] = mk(1, 0, 0, 64'hA,  1, 64'hA,  0, 0, 0, 1);
    tbl[13] = mk(1, 0, 0, 64'hB,  2, 64'hA,  0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 64'hC,  3, 64'hA,  0, 0, 0, 0);
    tbl[15] = mk(1, 1, 0, 64'hD,  3, 64'hB,  0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 64'h0,  2, 64'hC,  0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 64'h0,  1, 64'hD,  0, 0, 0, 1);
    tbl[18] = mk(0, 1, 0, 64'h0,  0, 64'h0,  0, 0, 0, 1);
    tbl[19] = mk(1, 1, 0, 64'h77, 1, 64'h77, 0, 1, 0, 1);
    tbl[20] = mk(1, 0, 0, 64'h88, 2, 64'h77, 0, 1, 0, 0);
    tbl[21] = mk(1, 0, 1, 64'h99, 0, 64'h0,  0, 0, 0, 1);
    tbl[22] = mk(1, 0, 0, 64'h12, 1, 64'h12, 0, 0, 0, 1);
    tbl[23] = mk(0, 1, 0, 64'h0,  0, 64'h0,  0, 0, 0, 1);
    tbl[24] = mk(1, 0, 0, 64'h34, 0, 64'h0,  0, 0, 0, 1);
    tbl[24].wce = 1'b0;
    tbl[25] = mk(0, 1, 0, 64'h0,  0, 64'h0,  0, 0, 0, 1);
    tbl[25].rce = 1'b0;

    reset_n = 1'b0;
    if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0; if_flush = 0; if_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("reset");

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].w, tbl[i].wce, tbl[i].r, tbl[i].rce, tbl[i].fl, tbl[i].din);
      tag = $sformatf("vec%0d", i);
      chk({tag, ".count"},   64'(if_count), 64'(tbl[i].cnt));
      chk({tag, ".empty_n"}, 64'(if_empty_n), 64'(tbl[i].cnt > 0));
      chk({tag, ".full_n"},  64'(if_full_n), 64'(tbl[i].cnt < D));
      chk({tag, ".af"},      64'(if_almost_full), 64'(tbl[i].af));
      chk({tag, ".ae"},      64'(if_almost_empty), 64'(tbl[i].ae));
      chk({tag, ".ovf"},     64'(if_ovf), 64'(tbl[i].ovf));
      chk({tag, ".udf"},     64'(if_udf), 64'(tbl[i].udf));
      if (tbl[i].cnt > 0) chk({tag, ".dout"}, if_dout, tbl[i].dout);
    end

    // Asynchronous reset between edges with four entries queued.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 0, 64'hF0 + 64'(i));
    chk("prerst.count", 64'(if_count), 64'd4);
    drive(0, 1, 0, 1, 0, 64'h0);
    #3 reset_n = 1'b0;
    #1 check_reset_state("async_rst");
    #2 reset_n = 1'b1;
    drive(1, 1, 0, 1, 0, 64'hC0FFEE);
    chk("postrst.count", 64'(if_count), 64'd1);
    chk("postrst.dout",  if_dout, 64'hC0FFEE);
    chk("postrst.ae",    64'(if_almost_empty), 64'd1);

    // Random traffic against the queue model, starting from a flushed FIFO.
    mq.delete(); m_ovf = 0; m_udf = 0;
    model_apply(0, 1, 0, 1, 1, 64'h0);
    drive(0, 1, 0, 1, 1, 64'h0);
    check_model("rnd_init");
    for (int i = 0; i < 600; i++) begin
      bit w, wce, r, rce, fl;
      logic [63:0] din;
      w   = ($urandom_range(0, 99) < (i < 300 ? 70 : 35));
      r   = ($urandom_range(0, 99) < (i < 300 ? 40 : 65));
      wce = ($urandom_range(0, 99) < 85);
      rce = ($urandom_range(0, 99) < 85);
      fl  = ($urandom_range(0, 99) < 2);
      din = {$urandom, $urandom};
      model_apply(w, wce, r, rce, fl, din);
      drive(w, wce, r, rce, fl, din);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
